// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART FIFO controller
package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_SEND
    } tx_state_t;

    localparam int IRQ_RX_WM = 0;
    localparam int IRQ_TX_WM = 1;
    localparam int IRQ_OVF   = 2;
    localparam int IRQ_ERR   = 3;

    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sync_fifo_lvl.sv
// rtl/sync_fifo_lvl.sv - first-word-fall-through FIFO with occupancy counter
module sync_fifo_lvl #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] wr_data,
    input  logic          push,
    input  logic          pop,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a simultaneous push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (level == (AW + 1)'(DEPTH));
    assign empty   = (level == '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart.sv
// rtl/uart.sv - 8N1 serial transmitter/receiver core
module uart #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    input  logic       transmit,
    input  logic [7:0] tx_byte,
    output logic       received,
    output logic [7:0] rx_byte,
    output logic       is_receiving,
    output logic       is_transmitting,
    output logic       recv_error
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t     rx_st;
    logic          rx_meta, rx_s, rx_prev;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_sh;

    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic [8:0]    tx_sh;

    assign is_receiving = (rx_st != RX_IDLE);

    // Start detection is on a falling edge so a line stuck low after a bad stop bit does not retrigger.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            rx_prev    <= 1'b1;
            rx_st      <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_sh      <= '0;
            rx_byte    <= '0;
            received   <= 1'b0;
            recv_error <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_s       <= rx_meta;
            rx_prev    <= rx_s;
            received   <= 1'b0;
            recv_error <= 1'b0;
            case (rx_st)
                RX_IDLE: if (rx_prev && !rx_s) begin
                    rx_st  <= RX_START;
                    rx_cnt <= HALF_BIT;
                end
                RX_START: if (rx_cnt == '0) begin
                    if (!rx_s) begin
                        rx_st  <= RX_DATA;
                        rx_cnt <= FULL_BIT;
                        rx_bit <= '0;
                    end else begin
                        rx_st <= RX_IDLE;
                    end
                end else begin
                    rx_cnt <= rx_cnt - 1'b1;
                end
                RX_DATA: if (rx_cnt == '0) begin
                    rx_sh  <= {rx_s, rx_sh[7:1]};
                    rx_cnt <= FULL_BIT;
                    rx_bit <= rx_bit + 1'b1;
                    if (rx_bit == 3'd7) rx_st <= RX_STOP;
                end else begin
                    rx_cnt <= rx_cnt - 1'b1;
                end
                RX_STOP: if (rx_cnt == '0) begin
                    rx_st <= RX_IDLE;
                    if (rx_s) begin
                        received <= 1'b1;
                        rx_byte  <= rx_sh;
                    end else begin
                        recv_error <= 1'b1;
                    end
                end else begin
                    rx_cnt <= rx_cnt - 1'b1;
                end
                default: rx_st <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx              <= 1'b1;
            is_transmitting <= 1'b0;
            tx_cnt          <= '0;
            tx_bit          <= '0;
            tx_sh           <= '1;
        end else if (!is_transmitting) begin
            if (transmit) begin
                is_transmitting <= 1'b1;
                tx              <= 1'b0;
                tx_sh           <= {1'b1, tx_byte};
                tx_cnt          <= FULL_BIT;
                tx_bit          <= '0;
            end
        end else if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - 1'b1;
        end else begin
            tx_cnt <= FULL_BIT;
            if (tx_bit == 4'd9) begin
                is_transmitting <= 1'b0;
            end else begin
                tx     <= tx_sh[0];
                tx_sh  <= {1'b1, tx_sh[8:1]};
                tx_bit <= tx_bit + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// rtl/uart_fifo_ctrl.sv - UART core wrapped with TX/RX FIFOs, launch FSM, status and interrupt
module uart_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int TX_AW        = 4,
    parameter int RX_AW        = 4,
    parameter int RX_WM        = 8,
    parameter int TX_WM        = 2,
    parameter int CLKS_PER_BIT = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [7:0]     tx_data,
    input  logic           tx_push,
    output logic           tx_full,
    output logic [TX_AW:0] tx_level,
    output logic [7:0]     rx_data,
    input  logic           rx_pop,
    output logic           rx_empty,
    output logic [RX_AW:0] rx_level,
    input  logic           rx,
    output logic           tx,
    input  logic           loopback,
    input  logic [3:0]     irq_en,
    input  logic           status_clr,
    output logic           rx_err,
    output logic           rx_ovf,
    output logic           tx_ovf,
    output logic           irq,
    output logic           busy
);

    logic       core_tx, core_rx;
    logic       core_transmit;
    logic [7:0] core_tx_byte;
    logic       core_received, core_recv_error;
    logic [7:0] core_rx_byte;
    logic       core_is_rx, core_is_tx;

    logic       tx_pop, tx_empty;
    logic [7:0] tx_head;
    logic       rx_full;
    logic       tx_drop, rx_drop;
    logic [3:0] irq_vec;
    tx_state_t  tx_state;

    assign core_rx = loopback ? core_tx : rx;
    assign tx      = loopback ? UART_IDLE_LEVEL : core_tx;

    uart #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
        .clk             (clk),
        .rst             (rst),
        .rx              (core_rx),
        .tx              (core_tx),
        .transmit        (core_transmit),
        .tx_byte         (core_tx_byte),
        .received        (core_received),
        .rx_byte         (core_rx_byte),
        .is_receiving    (core_is_rx),
        .is_transmitting (core_is_tx),
        .recv_error      (core_recv_error)
    );

    sync_fifo_lvl #(.DW(8), .AW(TX_AW)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_data (tx_data),
        .push    (tx_push),
        .pop     (tx_pop),
        .rd_data (tx_head),
        .full    (tx_full),
        .empty   (tx_empty),
        .level   (tx_level)
    );

    sync_fifo_lvl #(.DW(8), .AW(RX_AW)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_data (core_rx_byte),
        .push    (core_received),
        .pop     (rx_pop),
        .rd_data (rx_data),
        .full    (rx_full),
        .empty   (rx_empty),
        .level   (rx_level)
    );

    // When full the FIFO is never empty, so any pop makes room for the push.
    assign tx_drop = tx_push && tx_full && !tx_pop;
    assign rx_drop = core_received && rx_full && !rx_pop;

    // Strobe and pop are issued together once per byte; START/SEND follow the core's busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state      <= TX_IDLE;
            core_transmit <= 1'b0;
            tx_pop        <= 1'b0;
            core_tx_byte  <= '0;
        end else begin
            core_transmit <= 1'b0;
            tx_pop        <= 1'b0;
            case (tx_state)
                TX_IDLE: if (!tx_empty && !core_is_tx) begin
                    core_transmit <= 1'b1;
                    tx_pop        <= 1'b1;
                    core_tx_byte  <= tx_head;
                    tx_state      <= TX_START;
                end
                TX_START: if (core_is_tx)  tx_state <= TX_SEND;
                TX_SEND:  if (!core_is_tx) tx_state <= TX_IDLE;
                default:  tx_state <= TX_IDLE;
            endcase
        end
    end

    assign busy = core_is_rx || core_is_tx || (tx_state != TX_IDLE);

    assign irq_vec[IRQ_RX_WM] = (rx_level >= (RX_AW + 1)'(RX_WM));
    assign irq_vec[IRQ_TX_WM] = (tx_level <= (TX_AW + 1)'(TX_WM));
    assign irq_vec[IRQ_OVF]   = rx_ovf || tx_ovf;
    assign irq_vec[IRQ_ERR]   = rx_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_err <= 1'b0;
            rx_ovf <= 1'b0;
            tx_ovf <= 1'b0;
            irq    <= 1'b0;
        end else begin
            rx_err <= (rx_err && !status_clr) || core_recv_error;
            rx_ovf <= (rx_ovf && !status_clr) || rx_drop;
            tx_ovf <= (tx_ovf && !status_clr) || tx_drop;
            irq    <= |(irq_en & irq_vec);
        end
    end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb/tb_uart_fifo_ctrl.sv - directed self-checking bench for uart_fifo_ctrl
module tb_uart_fifo_ctrl;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_push;
    logic       tx_full;
    logic [4:0] tx_level;
    logic [7:0] rx_data;
    logic       rx_pop;
    logic       rx_empty;
    logic [4:0] rx_level;
    logic       rx;
    logic       tx;
    logic       loopback;
    logic [3:0] irq_en;
    logic       status_clr;
    logic       rx_err, rx_ovf, tx_ovf, irq, busy;

    int n_vec = 0;
    int n_bad = 0;
    int strobe_cnt = 0;
    int tx_low_cnt = 0;

    always #5 clk = ~clk;

    uart_fifo_ctrl #(
        .TX_AW(4), .RX_AW(4), .RX_WM(8), .TX_WM(2), .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_push(tx_push), .tx_full(tx_full),
        .tx_level(tx_level), .rx_data(rx_data), .rx_pop(rx_pop), .rx_empty(rx_empty),
        .rx_level(rx_level), .rx(rx), .tx(tx), .loopback(loopback), .irq_en(irq_en),
        .status_clr(status_clr), .rx_err(rx_err), .rx_ovf(rx_ovf), .tx_ovf(tx_ovf),
        .irq(irq), .busy(busy)
    );

    always @(negedge clk) begin
        if (dut.core_transmit === 1'b1) strobe_cnt++;
        if (loopback === 1'b1 && tx !== 1'b1) tx_low_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    // Drives one 8N1 frame on rx; optionally pops RX in the cycle the receiver completes.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input logic pop_at_end, input int stop_len);
        logic [9:0] bits;
        logic       was_busy;
        bits = {stop_bit, b, 1'b0};
        was_busy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            for (int c = 0; c < ((i == 9) ? stop_len : CPB); c++) begin
                @(negedge clk);
                rx_pop = pop_at_end && was_busy && !busy;
                was_busy = busy;
            end
        end
        rx = 1'b1;
        rx_pop = 1'b0;
    endtask

    initial begin
        int k;
        int s0, l0;
        rst = 1'b1; tx_data = '0; tx_push = 1'b0; rx_pop = 1'b0; rx = 1'b1;
        loopback = 1'b0; irq_en = '0; status_clr = 1'b0;

        // Reset and idle
        do_reset();
        tick(20);
        check("rst_tx", tx, 1'b1);
        check("rst_rx_empty", rx_empty, 1'b1);
        check("rst_tx_level", tx_level, 5'd0);
        check("rst_rx_level", rx_level, 5'd0);
        check("rst_tx_full", tx_full, 1'b0);
        check("rst_irq", irq, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sticky", {rx_err, rx_ovf, tx_ovf}, 3'b000);
        irq_en = 4'b0010;
        tick(2);
        check("tx_wm_irq_empty", irq, 1'b1);
        irq_en = 4'b0000;
        tick(2);
        check("irq_masked", irq, 1'b0);

        // Loopback: three bytes out and back
        do_reset();
        loopback = 1'b1;
        tick(1);
        s0 = strobe_cnt;
        l0 = tx_low_cnt;
        tx_push = 1'b1;
        tx_data = 8'h55; tick(1);
        tx_data = 8'hA3; tick(1);
        tx_data = 8'h00; tick(1);
        tx_push = 1'b0;
        k = 0;
        while (rx_level != 5'd3 && k < 2000) begin tick(1); k++; end
        check("lb_level_timeout", k < 2000, 1'b1);
        k = 0;
        while (busy && k < 200) begin tick(1); k++; end
        check("lb_idle_timeout", k < 200, 1'b1);
        check("lb_rx_level", rx_level, 5'd3);
        check("lb_rx_data0", rx_data, 8'h55);
        rx_pop = 1'b1; tick(1); rx_pop = 1'b0;
        check("lb_rx_data1", rx_data, 8'hA3);
        rx_pop = 1'b1; tick(1); rx_pop = 1'b0;
        check("lb_rx_data2", rx_data, 8'h00);
        rx_pop = 1'b1; tick(1); rx_pop = 1'b0;
        check("lb_rx_empty", rx_empty, 1'b1);
        check("lb_strobes", strobe_cnt - s0, 3);
        check("lb_tx_pin_low", tx_low_cnt - l0, 0);
        check("lb_rx_err", rx_err, 1'b0);
        loopback = 1'b0;

        // TX overflow while the core is busy with a frame
        do_reset();
        tx_data = 8'h01; tx_push = 1'b1; tick(1); tx_push = 1'b0;
        tick(6);
        check("tx_first_popped", tx_level, 5'd0);
        check("tx_busy", busy, 1'b1);
        for (int i = 0; i < 16; i++) begin
            tx_data = 8'(8'h20 + i);
            tx_push = 1'b1;
            tick(1);
        end
        check("tx_level_16", tx_level, 5'd16);
        check("tx_full", tx_full, 1'b1);
        check("tx_ovf_before", tx_ovf, 1'b0);
        tx_data = 8'hEE; tick(1); tx_push = 1'b0;
        check("tx_ovf_set", tx_ovf, 1'b1);
        check("tx_level_held", tx_level, 5'd16);
        irq_en = 4'b0100;
        tick(1);
        check("ovf_irq", irq, 1'b1);
        status_clr = 1'b1; tick(1); status_clr = 1'b0;
        check("tx_ovf_clr", tx_ovf, 1'b0);
        tick(1);
        check("ovf_irq_clr", irq, 1'b0);
        irq_en = 4'b0000;

        // RX overflow and pop coinciding with a receive at full
        do_reset();
        for (int i = 0; i < 16; i++) send_frame(8'(8'h10 + i), 1'b1, 1'b0, CPB);
        check("rx_level_16", rx_level, 5'd16);
        check("rx_ovf_before", rx_ovf, 1'b0);
        send_frame(8'hAA, 1'b1, 1'b0, CPB);
        check("rx_ovf_set", rx_ovf, 1'b1);
        check("rx_level_held", rx_level, 5'd16);
        check("rx_head_first", rx_data, 8'h10);
        status_clr = 1'b1; tick(1); status_clr = 1'b0;
        check("rx_ovf_clr", rx_ovf, 1'b0);
        send_frame(8'hBB, 1'b1, 1'b1, CPB);
        tick(1);
        check("rx_pushpop_level", rx_level, 5'd16);
        check("rx_pushpop_ovf", rx_ovf, 1'b0);
        check("rx_pushpop_head", rx_data, 8'h11);
        rx_pop = 1'b1; tick(15); rx_pop = 1'b0;
        check("rx_newest_stored", rx_data, 8'hBB);
        check("rx_level_1", rx_level, 5'd1);

        // RX watermark interrupt
        do_reset();
        irq_en = 4'b0001;
        for (int i = 0; i < 7; i++) send_frame(8'(8'h40 + i), 1'b1, 1'b0, CPB);
        tick(2);
        check("wm_level_7", rx_level, 5'd7);
        check("wm_irq_7", irq, 1'b0);
        send_frame(8'h47, 1'b1, 1'b0, 1);
        k = 0;
        while (rx_level != 5'd8 && k < 40) begin tick(1); k++; end
        check("wm_level_timeout", k < 40, 1'b1);
        check("wm_irq_lag", irq, 1'b0);
        tick(1);
        check("wm_irq_8", irq, 1'b1);
        rx_pop = 1'b1; tick(1); rx_pop = 1'b0;
        check("wm_pop_level", rx_level, 5'd7);
        tick(1);
        check("wm_irq_after_pop", irq, 1'b0);
        irq_en = 4'b0000;

        // Bad stop bit, then reset mid transmit frame
        do_reset();
        send_frame(8'h5A, 1'b1, 1'b0, CPB);
        check("err_good_level", rx_level, 5'd1);
        send_frame(8'h66, 1'b0, 1'b0, CPB);
        tick(2);
        check("err_set", rx_err, 1'b1);
        check("err_level", rx_level, 5'd1);
        check("err_head", rx_data, 8'h5A);
        status_clr = 1'b1; tick(1); status_clr = 1'b0;
        check("err_clr", rx_err, 1'b0);
        tx_data = 8'h3C; tx_push = 1'b1; tick(1);
        tx_data = 8'h3D; tick(1); tx_push = 1'b0;
        tick(30);
        check("midframe_busy", busy, 1'b1);
        check("midframe_tx_level", tx_level, 5'd1);
        rst = 1'b1; tick(1); rst = 1'b0;
        check("rst_mid_tx", tx, 1'b1);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_tx_level", tx_level, 5'd0);
        check("rst_mid_rx_level", rx_level, 5'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
